hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core; drives the write-enable, flush and bubble controls of PC, IF_ID, ID_EX and EX_MEM buffers.
- Detects load-use hazards (load in EX, consumer in ID) and inserts LOAD_STALL_CYCLES bubbles.
- Flushes younger instructions on a taken branch resolved in MEM.
- Freezes the whole pipe while data memory reports busy.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of instruction in ID (bits 25:21).
- id_rt  in  REG_W  rt field of instruction in ID (bits 20:16).
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  MemRead bit of ID_EX M-control field.
- ex_rt  in  REG_W  ID_EX b20_16 output (load destination).
- mem_branch_taken  in  1  EX_MEM branch AND zero, resolved in MEM.
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads NOP.
- id_ex_bubble  out  1  ID_EX loads zero EX/M/WB controls.
- ex_mem_bubble  out  1  EX_MEM loads zero M/WB controls.
- pipe_hold  out  1  ID_EX, EX_MEM, MEM_WB hold current contents.

Behaviour:
- State register: RUN, LOAD_STALL, FLUSH; 3-bit stall counter cnt.
- Outputs are combinational from state and inputs (Mealy), so they act in the detecting cycle.
- RUN outputs (defaults): pc_write=1, if_id_write=1; all others 0.
- hazard = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
- Priority, highest first: rst > mem_busy > mem_branch_taken > hazard.
- rst=1:
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, pipe_hold=0.
  - Next: state=RUN, cnt=0.
  - Applies mid-stall or mid-flush; no state survives.
- mem_busy=1 (any state):
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1; flush/bubble outputs 0.
  - state and cnt hold.
  - mem_branch_taken and hazard are ignored that cycle; they are re-evaluated once mem_busy drops.
- mem_branch_taken=1, mem_busy=0 (any state):
  - Outputs: pc_write=1 (target load), if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, if_id_write=1.
  - Next: state=FLUSH, cnt=0.
  - Aborts any LOAD_STALL in progress.
- RUN, hazard=1:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_STALL_CYCLES=1, next=RUN; else next=LOAD_STALL with cnt=1.
- LOAD_STALL:
  - Outputs same as a hazard stall (pc_write=0, if_id_write=0, id_ex_bubble=1) regardless of hazard.
  - cnt increments each cycle.
  - When cnt==LOAD_STALL_CYCLES-1, next=RUN and cnt=0.
- FLUSH:
  - Lasts exactly one cycle; outputs as RUN, except hazard is masked (ID holds the flushed NOP).
  - Next=RUN.
- Register 0 never causes a stall.
- At most one of {stall, flush, hold} patterns is active in any cycle.

Optional Feature:
- Macro: HAZARD_CTRL_STATS_EN.
- Defined:
  - Adds output stall_count[15:0], counting cycles with pc_write=0 and rst=0.
  - Saturates at 16'hFFFF; cleared to 0 by rst.
  - Adds output flush_count[15:0], incremented on each accepted mem_branch_taken; same saturation and clear rules.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then deassert -> during reset pc_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1; first cycle after reset pc_write=1, if_id_write=1.
- Load-use, LOAD_STALL_CYCLES=1: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (ex_mem_read=0) returns to RUN outputs.
- Load-use, LOAD_STALL_CYCLES=3: ex_rt=9, id_rt=9, id_uses_rt=1 -> exactly 3 consecutive stall cycles. Repeat with id_uses_rt=0 -> no stall. Repeat with ex_rt=0 -> no stall.
- Branch mid-stall (LOAD_STALL_CYCLES=3): mem_branch_taken=1 in 2nd stall cycle -> that cycle pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1. Next cycle FLUSH: a hazard pattern on inputs produces no stall. Then RUN.
- mem_busy: assert mem_busy for 4 cycles during the 1st cycle of a LOAD_STALL_CYCLES=2 stall, with mem_branch_taken=1 also held -> 4 cycles pipe_hold=1, pc_write=0, no flush. Then branch flush on the release cycle.
- Reset mid-operation: rst=1 during LOAD_STALL -> next cycle after release is RUN. With HAZARD_CTRL_STATS_EN, stall_count=0 after rst and increments to 1 after one load-use stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage MIPS core (PC, IF_ID, ID_EX, EX_MEM controls).
// Latency: outputs are Mealy (combinational from state and inputs) and act in the detecting cycle.
// Backpressure: mem_busy freezes the whole pipe; load-use inserts bubbles; taken branch flushes.
// Optional build macro HAZARD_CTRL_STATS_EN adds saturating stall_count / flush_count outputs.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,   // bubbles per load-use hazard, 1..7
  parameter int REG_W             = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
`ifdef HAZARD_CTRL_STATS_EN
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count,
`endif
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             pipe_hold
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;

  // Last stall cycle index; cnt counts stall cycles already issued.
  localparam logic [2:0] CNT_LAST = 3'(LOAD_STALL_CYCLES - 1);

  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  assign hazard = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and Mealy outputs, priority rst > mem_busy > branch > hazard.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    pipe_hold     = 1'b0;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = RUN;
      cnt_d         = 3'd0;
    end else if (mem_busy) begin
      // Freeze everything; branch and hazard are re-evaluated after release.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (mem_branch_taken) begin
      // Load the branch target and squash the three younger instructions.
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = FLUSH;
      cnt_d         = 3'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = 3'd1;
            end
          end
        end
        LOAD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        FLUSH: begin
          // ID holds the flushed NOP, so any hazard match is spurious.
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters: cycles without PC advance, and accepted branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (!mem_busy && mem_branch_taken && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
